// File: rtl/sta_arc_scheduler_if.sv
// Arc-stream and query handshake between the netlist arc streamer and the
// arrival-time propagation engine.
interface sta_arc_scheduler_if #(
  parameter int NW = 6,
  parameter int DW = 16
);
  logic          arc_valid;
  logic          arc_ready;
  logic [NW-1:0] arc_from;
  logic [NW-1:0] arc_to;
  logic [DW-1:0] arc_delay;
  logic          q_req;
  logic [NW-1:0] q_node;
  logic          q_ack;
  logic [DW-1:0] q_at;

  modport master (
    output arc_valid, arc_from, arc_to, arc_delay, q_req, q_node,
    input  arc_ready, q_ack, q_at
  );

  modport slave (
    input  arc_valid, arc_from, arc_to, arc_delay, q_req, q_node,
    output arc_ready, q_ack, q_at
  );
endinterface

// File: rtl/sta_arc_scheduler.sv
// Arrival-time propagation engine: AT[to] = max(AT[to], sat(AT[from] + delay)),
// one arc per cycle through a two-stage pipeline with same-cycle write bypass.
module sta_arc_scheduler #(
  parameter int NODES = 64,
  parameter int NW    = 6,
  parameter int DW    = 16
) (
  input  logic                CP,
  input  logic                CD,
  input  logic                clr,
  sta_arc_scheduler_if.slave  bus,
  output logic                busy,
  output logic [15:0]         arc_cnt,
  output logic [DW-1:0]       worst_at,
  output logic [NW-1:0]       worst_node
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic [NW-1:0] clr_idx_q, clr_idx_d;
  logic          s2_valid_q, s2_valid_d;
  logic [NW-1:0] s2_to_q, s2_to_d;
  logic [DW-1:0] s2_sum_q, s2_sum_d;
  logic          q_ack_q, q_ack_d;
  logic [DW-1:0] q_at_q, q_at_d;
  logic [15:0]   arc_cnt_q, arc_cnt_d;
  logic [DW-1:0] worst_at_q, worst_at_d;
  logic [NW-1:0] worst_node_q, worst_node_d;

  logic [DW-1:0] at_mem [NODES];
  logic          at_we;
  logic [NW-1:0] at_wa;
  logic [DW-1:0] at_wd;
  logic [DW-1:0] s2_old, wr_max, from_at, query_at;
  logic [DW:0]   sum_full;
  logic          run_open, accept;

  assign run_open      = (state_q == ST_RUN) && !clr;
  assign accept        = run_open && bus.arc_valid;
  assign bus.arc_ready = run_open;
  assign bus.q_ack     = q_ack_q;
  assign bus.q_at      = q_at_q;
  assign busy          = (state_q == ST_CLEAR) || s2_valid_q;
  assign arc_cnt       = arc_cnt_q;
  assign worst_at      = worst_at_q;
  assign worst_node    = worst_node_q;

  // Single write port: the clear sweep owns it in CLEAR, the S2 max-write in RUN.
  always_comb begin
    s2_old = at_mem[s2_to_q];
    wr_max = (s2_sum_q > s2_old) ? s2_sum_q : s2_old;
    at_we  = 1'b0;
    at_wa  = s2_to_q;
    at_wd  = wr_max;
    if (state_q == ST_CLEAR) begin
      at_we = 1'b1;
      at_wa = clr_idx_q;
      at_wd = '0;
    end else if (s2_valid_q) begin
      at_we = 1'b1;
    end
  end

  always_comb begin
    from_at  = (at_we && (at_wa == bus.arc_from)) ? at_wd : at_mem[bus.arc_from];
    query_at = (at_we && (at_wa == bus.q_node))   ? at_wd : at_mem[bus.q_node];
    sum_full = {1'b0, from_at} + {1'b0, bus.arc_delay};
  end

  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    s2_valid_d   = accept;
    s2_to_d      = bus.arc_to;
    s2_sum_d     = sum_full[DW] ? {DW{1'b1}} : sum_full[DW-1:0];
    q_ack_d      = bus.q_req;
    q_at_d       = bus.q_req ? query_at : q_at_q;
    arc_cnt_d    = arc_cnt_q;
    worst_at_d   = worst_at_q;
    worst_node_d = worst_node_q;

    case (state_q)
      ST_CLEAR: begin
        if (clr) begin
          clr_idx_d = '0;
        end else if (clr_idx_q == NW'(NODES - 1)) begin
          clr_idx_d = '0;
          state_d   = ST_RUN;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (clr) begin
          clr_idx_d = '0;
          state_d   = ST_CLEAR;
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    if (s2_valid_q && (arc_cnt_q != 16'hFFFF)) arc_cnt_d = arc_cnt_q + 16'd1;
    if (s2_valid_q && (wr_max > worst_at_q)) begin
      worst_at_d   = wr_max;
      worst_node_d = s2_to_q;
    end
    // Statistics restart on every entry into CLEAR and stay zero throughout it.
    if (state_d == ST_CLEAR) begin
      arc_cnt_d    = '0;
      worst_at_d   = '0;
      worst_node_d = '0;
    end
  end

  always_ff @(posedge CP or posedge CD) begin
    if (CD) begin
      state_q      <= ST_CLEAR;
      clr_idx_q    <= '0;
      s2_valid_q   <= 1'b0;
      s2_to_q      <= '0;
      s2_sum_q     <= '0;
      q_ack_q      <= 1'b0;
      q_at_q       <= '0;
      arc_cnt_q    <= '0;
      worst_at_q   <= '0;
      worst_node_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      s2_valid_q   <= s2_valid_d;
      s2_to_q      <= s2_to_d;
      s2_sum_q     <= s2_sum_d;
      q_ack_q      <= q_ack_d;
      q_at_q       <= q_at_d;
      arc_cnt_q    <= arc_cnt_d;
      worst_at_q   <= worst_at_d;
      worst_node_q <= worst_node_d;
    end
  end

  always_ff @(posedge CP) begin
    if (at_we && !CD) at_mem[at_wa] <= at_wd;
  end

endmodule

// File: tb/tb_sta_arc_scheduler.sv
// Self-checking bench for sta_arc_scheduler: arc vector table, query scoreboard,
// sequential reference model, and clear/reset corner sequences.
module tb_sta_arc_scheduler;

  logic        CP = 1'b0;
  logic        CD = 1'b1;
  logic        clr = 1'b0;
  logic        busy;
  logic [15:0] arc_cnt;
  logic [15:0] worst_at;
  logic [5:0]  worst_node;

  sta_arc_scheduler_if #(.NW(6), .DW(16)) bus();

  sta_arc_scheduler #(.NODES(64), .NW(6), .DW(16)) dut (
    .CP(CP), .CD(CD), .clr(clr), .bus(bus),
    .busy(busy), .arc_cnt(arc_cnt), .worst_at(worst_at), .worst_node(worst_node)
  );

  always #5 CP = ~CP;

  typedef struct {
    logic [5:0]  from;
    logic [5:0]  to;
    logic [15:0] delay;
    logic [5:0]  qn;
    logic [15:0] exp_at;
  } vec_t;

  vec_t        tbl [9];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q [$];

  logic [15:0] m_at [64];
  logic [15:0] m_cnt;
  logic [15:0] m_worst;
  logic [5:0]  m_wnode;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_at[i] = 16'h0000;
    m_cnt   = 16'h0000;
    m_worst = 16'h0000;
    m_wnode = 6'd0;
  endtask

  task automatic model_arc(input logic [5:0] f, input logic [5:0] t, input logic [15:0] d);
    logic [16:0] s;
    logic [15:0] v;
    s = {1'b0, m_at[f]} + {1'b0, d};
    v = s[16] ? 16'hFFFF : s[15:0];
    if (m_at[t] > v) v = m_at[t];
    m_at[t] = v;
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (v > m_worst) begin
      m_worst = v;
      m_wnode = t;
    end
  endtask

  // Query scoreboard: expected value pushed at request, popped on q_ack.
  always @(negedge CP) begin
    if (bus.q_ack) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL q_ack_unexpected: got q_ack=1, expected no pending query");
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("q_at", 32'(bus.q_at), 32'(e));
      end
    end
  end

  task automatic drive_arc(input logic [5:0] f, input logic [5:0] t, input logic [15:0] d);
    @(negedge CP);
    clr           = 1'b0;
    bus.q_req     = 1'b0;
    bus.arc_valid = 1'b1;
    bus.arc_from  = f;
    bus.arc_to    = t;
    bus.arc_delay = d;
    #1 check("arc_ready_run", 32'(bus.arc_ready), 32'd1);
    model_arc(f, t, d);
  endtask

  task automatic query(input logic [5:0] n, input logic [15:0] e);
    @(negedge CP);
    bus.arc_valid = 1'b0;
    bus.q_req     = 1'b1;
    bus.q_node    = n;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CP);
      bus.arc_valid = 1'b0;
      bus.q_req     = 1'b0;
    end
  endtask

  task automatic wait_run(input string name);
    int cyc = 0;
    while (!bus.arc_ready && cyc < 200) begin
      @(posedge CP);
      #1 cyc++;
    end
    check(name, 32'(cyc), 32'd64);
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.arc_valid = 1'b0;
    bus.arc_from  = '0;
    bus.arc_to    = '0;
    bus.arc_delay = '0;
    bus.q_req     = 1'b0;
    bus.q_node    = '0;
    model_clear();

    tbl[0] = '{6'd0, 6'd5, 16'h0300, 6'd5, 16'h0300};
    tbl[1] = '{6'd1, 6'd5, 16'h0100, 6'd5, 16'h068C};
    tbl[2] = '{6'd0, 6'd5, 16'h0200, 6'd5, 16'h068C};
    tbl[3] = '{6'd0, 6'd3, 16'hFF00, 6'd3, 16'hFF00};
    tbl[4] = '{6'd3, 6'd4, 16'h0200, 6'd4, 16'hFFFF};
    tbl[5] = '{6'd7, 6'd7, 16'h0010, 6'd7, 16'h0010};
    tbl[6] = '{6'd7, 6'd7, 16'h0010, 6'd7, 16'h0020};
    tbl[7] = '{6'd2, 6'd8, 16'h0000, 6'd8, 16'h07EF};
    tbl[8] = '{6'd4, 6'd9, 16'h0001, 6'd9, 16'hFFFF};

    // Reset values, then the initial clear sweep.
    repeat (3) @(negedge CP);
    check("rst_arc_ready", 32'(bus.arc_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_q_ack", 32'(bus.q_ack), 32'd0);
    check("rst_q_at", 32'(bus.q_at), 32'd0);
    check("rst_arc_cnt", 32'(arc_cnt), 32'd0);
    check("rst_worst_at", 32'(worst_at), 32'd0);
    CD = 1'b0;
    wait_run("init_clear_cycles");
    query(6'd0, 16'h0000);
    query(6'd63, 16'h0000);
    idle(1);

    // Dependent back-to-back arcs exercise the S1 read bypass.
    drive_arc(6'd0, 6'd1, 16'h058C);
    drive_arc(6'd1, 6'd2, 16'h0263);
    query(6'd1, 16'h058C);
    query(6'd2, 16'h07EF);
    idle(2);
    check("bypass_arc_cnt", 32'(arc_cnt), 32'd2);
    check("bypass_worst_at", 32'(worst_at), 32'h07EF);
    check("bypass_worst_node", 32'(worst_node), 32'd2);

    for (int i = 0; i < 9; i++) begin
      drive_arc(tbl[i].from, tbl[i].to, tbl[i].delay);
      query(tbl[i].qn, tbl[i].exp_at);
    end
    idle(2);
    check("tbl_arc_cnt", 32'(arc_cnt), 32'd11);
    check("tbl_worst_at", 32'(worst_at), 32'hFFFF);
    check("tbl_worst_node", 32'(worst_node), 32'd4);

    // clr while an arc sits in S2: the write lands and is visible to a same-cycle query.
    drive_arc(6'd2, 6'd6, 16'h0100);
    @(negedge CP);
    bus.arc_valid = 1'b0;
    clr           = 1'b1;
    bus.q_req     = 1'b1;
    bus.q_node    = 6'd6;
    exp_q.push_back(16'h08EF);
    #1;
    check("clr_arc_ready", 32'(bus.arc_ready), 32'd0);
    check("clr_arc_cnt_before", 32'(arc_cnt), 32'd11);
    @(negedge CP);
    clr       = 1'b0;
    bus.q_req = 1'b0;
    check("clr_arc_cnt", 32'(arc_cnt), 32'd0);
    check("clr_worst_at", 32'(worst_at), 32'd0);
    check("clr_worst_node", 32'(worst_node), 32'd0);
    check("clr_busy", 32'(busy), 32'd1);
    model_clear();
    wait_run("clr_clear_cycles");
    for (int n = 0; n < 10; n++) query(6'(n), m_at[n]);
    idle(2);

    // Random back-to-back stream against the sequential model.
    for (int i = 0; i < 40; i++) begin
      drive_arc(6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)),
                16'($urandom_range(0, 16'h1FFF)));
    end
    for (int n = 0; n < 16; n++) query(6'(n), m_at[n]);
    idle(2);
    check("rnd_arc_cnt", 32'(arc_cnt), 32'(m_cnt));
    check("rnd_worst_at", 32'(worst_at), 32'(m_worst));
    check("rnd_worst_node", 32'(worst_node), 32'(m_wnode));

    // Asynchronous reset with arcs in flight.
    drive_arc(6'd0, 6'd1, 16'h0100);
    drive_arc(6'd1, 6'd2, 16'h0100);
    #2 CD = 1'b1;
    #1;
    check("cd_arc_ready", 32'(bus.arc_ready), 32'd0);
    check("cd_busy", 32'(busy), 32'd1);
    check("cd_arc_cnt", 32'(arc_cnt), 32'd0);
    check("cd_worst_at", 32'(worst_at), 32'd0);
    check("cd_worst_node", 32'(worst_node), 32'd0);
    check("cd_q_at", 32'(bus.q_at), 32'd0);
    @(negedge CP);
    bus.arc_valid = 1'b0;
    @(negedge CP);
    CD = 1'b0;
    model_clear();
    wait_run("cd_clear_cycles");
    query(6'd1, 16'h0000);
    query(6'd2, 16'h0000);
    query(6'd5, 16'h0000);
    idle(3);
    check("cd_arc_cnt_after", 32'(arc_cnt), 32'd0);
    check("q_pending", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
